// File: rtl/md_sched_if.sv
// Bundle of the E-stage multiply/divide issue signals, the architectural HI/LO
// results and the D-stage stall, shared between the pipeline and md_sched.
interface md_sched_if;
  // Handshake: start is the valid for {op, a, b}. The unit is ready while it is
  // IDLE and req is low. An operation transfers only on a clock edge where
  // valid and ready are both high; at any other time start is ignored.
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        d_uses_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        dbg_state;
  logic [3:0]  dbg_count;

  modport master (
    output start, op, a, b, req, d_uses_md,
    input  hi, lo, busy, stall, dbg_state, dbg_count
  );

  modport slave (
    input  start, op, a, b, req, d_uses_md,
    output hi, lo, busy, stall, dbg_state, dbg_count
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer: computes the result at issue, holds HI/LO busy for
// a fixed latency, then commits both registers together.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  md_sched_if.slave md
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  count_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;

  logic        is_long, is_mul, is_move, accept;
  logic [31:0] res_hi, res_lo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign is_long = (md.op >= OP_MULT) && (md.op <= OP_DIVU);
  assign is_mul  = (md.op == OP_MULT) || (md.op == OP_MULTU);
  assign is_move = (md.op == OP_MTHI) || (md.op == OP_MTLO);
  assign accept  = md.start && !md.req && (state_q == IDLE) && (is_long || is_move);

  // Full-width products; operands are explicitly extended to 64 bits.
  assign prod_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // A zero divisor is replaced so the dividers never see it; the result is
  // discarded in that case and HI/LO are carried through unchanged.
  assign divisor = (md.b == 32'd0) ? 32'd1 : md.b;
  assign quot_s  = $signed(md.a) / $signed(divisor);
  assign rem_s   = $signed(md.a) % $signed(divisor);
  assign quot_u  = md.a / divisor;
  assign rem_u   = md.a % divisor;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (md.op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (md.b != 32'd0) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (md.b != 32'd0) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_long) state_d = RUN;
      RUN:  if (count_q == 4'd1)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else if (state_q == IDLE) begin
      if (accept && is_long) begin
        pend_hi_q <= res_hi;
        pend_lo_q <= res_lo;
        count_q   <= is_mul ? MULT_LOAD : DIV_LOAD;
      end
      if (accept && (md.op == OP_MTHI)) hi_q <= md.a;
      if (accept && (md.op == OP_MTLO)) lo_q <= md.a;
    end else begin
      // Running: req and start are deliberately ignored until the commit edge.
      count_q <= count_q - 4'd1;
      if (count_q == 4'd1) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end

  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.busy      = (state_q == RUN);
  assign md.stall     = reset && md.d_uses_md &&
                        ((state_q == RUN) || (md.start && is_long && !md.req));
  assign md.dbg_state = state_q;
  assign md.dbg_count = count_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: reset, each MD operation, req cancellation,
// start during RUN, divide by zero and asynchronous reset mid-operation.
module tb_md_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] m_hi, m_lo;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic r, input logic d);
    bus.start     = s;
    bus.op        = o;
    bus.a         = x;
    bus.b         = y;
    bus.req       = r;
    bus.d_uses_md = d;
  endtask

  // Issue one long operation, walk its n busy cycles and check the commit.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input int req_cyc, input bit poke);
    drive(1'b1, o, x, y, 1'b0, 1'b1);
    #1;
    chk({name, "_issue_stall"}, 32'(bus.stall), 32'd1);
    step();
    for (int i = 1; i <= n; i++) begin
      drive(poke && (i == 2), 4'd5, 32'hDEAD_BEEF, 32'd0, (i == req_cyc), 1'b1);
      #1;
      chk({name, "_busy"}, 32'(bus.busy), 32'd1);
      chk({name, "_stall"}, 32'(bus.stall), 32'd1);
      chk({name, "_hold_hi"}, bus.hi, m_hi);
      chk({name, "_hold_lo"}, bus.lo, m_lo);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk({name, "_done_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_done_stall"}, 32'(bus.stall), 32'd0);
    chk({name, "_hi"}, bus.hi, eh);
    chk({name, "_lo"}, bus.lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;

    // Reset with a mult pending on the inputs: stall must stay low.
    reset = 1'b0;
    drive(1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    #3;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    step();
    step();
    chk("rst_held_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
    // Start during RUN (mthi) must not touch HI.
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 0, 1'b1);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op("divu", 4'd4, 32'hFFFF_FFFF, 32'd16, 10, 32'h0000_000F, 32'h0FFF_FFFF, 0, 1'b0);

    // mthi then mtlo back to back: zero latency, never busy, no stall.
    drive(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
    #1;
    chk("mthi_stall", 32'(bus.stall), 32'd0);
    step();
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    drive(1'b1, 4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", bus.hi, 32'h1234_5678);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // Op 7 is treated as none.
    drive(1'b1, 4'd7, 32'h5555_5555, 32'd1, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("op7_busy", 32'(bus.busy), 32'd0);
    chk("op7_hi", bus.hi, m_hi);

    // req with start: mult discarded, no stall from the issuing op.
    drive(1'b1, 4'd1, 32'd3, 32'd5, 1'b1, 1'b1);
    #1;
    chk("req_stall", 32'(bus.stall), 32'd0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("req_busy", 32'(bus.busy), 32'd0);
    chk("req_hi", bus.hi, m_hi);
    chk("req_lo", bus.lo, m_lo);
    step();
    chk("req_busy_later", 32'(bus.busy), 32'd0);

    // req in busy cycle 3 of a signed div: 100 / -7 = -14 rem 2.
    run_op("div_req", 4'd3, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2, 3, 1'b0);

    // Asynchronous reset in busy cycle 2 of a mult, then no late commit.
    drive(1'b1, 4'd1, 32'd3, 32'd5, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("arst_busy1", 32'(bus.busy), 32'd1);
    step();
    chk("arst_busy2", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("arst_after_busy", 32'(bus.busy), 32'd0);
    chk("arst_after_hi", bus.hi, 32'd0);
    chk("arst_after_lo", bus.lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the pipeline's multiply/divide resource, sitting in the E stage beside the ALU.
- Accepts one MD operation per issue and holds HI/LO busy for a fixed per-operation latency.
- Commits HI/LO atomically at completion and produces the D-stage stall for any instruction that touches HI/LO while the unit is occupied.
- Honours the interrupt request: an operation arriving in the same cycle as `req` is discarded.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  E-stage valid MD instruction this cycle
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7..15 treated as none
- a  in  32  forwarded rs operand
- b  in  32  forwarded rt operand
- req  in  1  exception/interrupt request from CP0; cancels the operation issued this cycle
- d_uses_md  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  unit occupied (RUN state)
- stall  out  1  D-stage stall request to the hazard unit

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=0, lo=0, busy=0, counter=0, pending regs=0.
  - stall=0 once reset is asserted, since start is don't-care in reset.
- Accept condition: `accept = start & ~req & state==IDLE & op in 1..6`.
- States: IDLE, RUN.
- IDLE, accept with op 1..4, at the edge:
  - Latch the result into pending_hi/pending_lo.
  - mult: signed 64-bit a*b. multu: unsigned a*b. HI=[63:32], LO=[31:0].
  - div: LO=signed a/b truncated toward zero, HI=signed remainder (sign follows a). divu: unsigned.
  - b==0 for div/divu: pending_hi=hi, pending_lo=lo (HI/LO unchanged at commit). Full latency is still spent.
  - Counter loaded with MULT_CYCLES or DIV_CYCLES; state goes to RUN.
- IDLE, accept with op 5/6: hi<=a (mthi) or lo<=a (mtlo) at that edge; state stays IDLE; latency 0 cycles of busy.
- RUN:
  - Counter decrements each cycle.
  - At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, state goes to IDLE.
  - busy=1 for exactly N cycles following the accept edge. New HI/LO are visible in the first cycle after busy falls.
- start while in RUN: ignored. It is a protocol violation that stall normally prevents; hi/lo/counter are unaffected.
- req during RUN: no effect. A started operation always completes, because its instruction has already retired past the exception point.
- req with start in the same cycle: op discarded, no state change.
- `stall = d_uses_md & (busy | (start & (op in 1..4) & ~req))` — combinational.
- hi/lo outputs are registered only; no bypass of pending values.
- Reset mid-RUN: operation aborted, state IDLE, hi=lo=0.
- All arithmetic is on 32-bit operands; the 64-bit product is computed at accept. No overflow detection.

Test Plan:
- Reset low, then high; issue mult a=0xFFFFFFFF (-1), b=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles; stall=1 whenever d_uses_md=1 during those cycles.
- div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=0 -> 10 busy cycles, hi/lo unchanged.
- mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated at each edge, busy never asserts.
- start op=mult with req=1 in the same cycle -> busy stays 0, hi/lo unchanged. req=1 in cycle 3 of a running div -> div still completes with the correct result.
- Assert reset low in busy cycle 2 of a mult -> busy=0, hi=lo=0 immediately (asynchronous), no later commit after release.
